// File: rtl/rr_mux4_1.sv
// rr_mux4_1: round-robin 4:1 valid/ready merger with a single registered output.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   a, b, c, d               channel data (channel index 0..3)
//   a_valid .. d_valid       channel word present
//   a_ready .. d_ready       channel word accepted this cycle (combinational)
//   y                        registered output data
//   s1, s2                   registered source channel index {s1,s2}
//   y_valid                  y/s1/s2 hold a word
//   y_ready                  downstream accepts the word this cycle
//
// The {s1,s2} tag uses the same encoding as the 1:4 demux select, so the
// demux can route each word back to the channel it came from.
module rr_mux4_1 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             a_valid,
  input  logic             b_valid,
  input  logic             c_valid,
  input  logic             d_valid,
  output logic             a_ready,
  output logic             b_ready,
  output logic             c_ready,
  output logic             d_ready,
  output logic [WIDTH-1:0] y,
  output logic             s1,
  output logic             s2,
  output logic             y_valid,
  input  logic             y_ready
);

  localparam int unsigned N_CH  = 4;
  localparam int unsigned IDX_W = 2;

  // Registered state
  logic [WIDTH-1:0] y_q,       y_d;
  logic [IDX_W-1:0] sel_q,     sel_d;
  logic             y_valid_q, y_valid_d;
  logic [IDX_W-1:0] ptr_q,     ptr_d;

  // Arbitration signals
  logic [N_CH-1:0]  valid_vec;
  logic [N_CH-1:0]  ready_vec;
  logic             can_load;
  logic             grant_vld;
  logic [IDX_W-1:0] grant_idx;
  logic             xfer;
  logic [WIDTH-1:0] data_sel;

  assign valid_vec = {d_valid, c_valid, b_valid, a_valid};

  // Output slot is free when empty or being drained this cycle
  assign can_load = !y_valid_q || y_ready;

  // Rotating-priority search; scanning from the farthest offset down lets the
  // nearest valid channel to ptr overwrite any earlier hit.
  always_comb begin
    logic [IDX_W-1:0] idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      idx = ptr_q + IDX_W'(i);
      if (valid_vec[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

  assign xfer = can_load && grant_vld;

  // One-hot ready toward the granted channel only
  always_comb begin
    ready_vec = '0;
    if (xfer) begin
      ready_vec[grant_idx] = 1'b1;
    end
  end

  assign a_ready = ready_vec[0];
  assign b_ready = ready_vec[1];
  assign c_ready = ready_vec[2];
  assign d_ready = ready_vec[3];

  // Data select for the granted channel
  always_comb begin
    data_sel = a;
    unique case (grant_idx)
      2'd0:    data_sel = a;
      2'd1:    data_sel = b;
      2'd2:    data_sel = c;
      2'd3:    data_sel = d;
      default: data_sel = a;
    endcase
  end

  // Next-state: load replaces (even while draining), else drain clears valid
  always_comb begin
    y_d       = y_q;
    sel_d     = sel_q;
    y_valid_d = y_valid_q;
    ptr_d     = ptr_q;
    if (xfer) begin
      y_d       = data_sel;
      sel_d     = grant_idx;
      y_valid_d = 1'b1;
      ptr_d     = grant_idx + IDX_W'(1);
    end else if (y_valid_q && y_ready) begin
      y_valid_d = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q       <= '0;
      sel_q     <= '0;
      y_valid_q <= 1'b0;
      ptr_q     <= '0;
    end else begin
      y_q       <= y_d;
      sel_q     <= sel_d;
      y_valid_q <= y_valid_d;
      ptr_q     <= ptr_d;
    end
  end

  assign y       = y_q;
  assign s1      = sel_q[1];
  assign s2      = sel_q[0];
  assign y_valid = y_valid_q;

endmodule

// File: tb/tb_rr_mux4_1.sv
// tb_rr_mux4_1: directed bench for rr_mux4_1 with hand-computed expectations.
module tb_rr_mux4_1;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] a, b, c, d;
  logic             a_valid, b_valid, c_valid, d_valid;
  logic             a_ready, b_ready, c_ready, d_ready;
  logic [WIDTH-1:0] y;
  logic             s1, s2;
  logic             y_valid;
  logic             y_ready;

  int n_checks = 0;
  int n_errors = 0;

  rr_mux4_1 #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .c       (c),
    .d       (d),
    .a_valid (a_valid),
    .b_valid (b_valid),
    .c_valid (c_valid),
    .d_valid (d_valid),
    .a_ready (a_ready),
    .b_ready (b_ready),
    .c_ready (c_ready),
    .d_ready (d_ready),
    .y       (y),
    .s1      (s1),
    .s2      (s2),
    .y_valid (y_valid),
    .y_ready (y_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; sample 1 ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Valids given as {d,c,b,a}
  task automatic set_v(input logic [3:0] v);
    {d_valid, c_valid, b_valid, a_valid} = v;
  endtask

  // Ready vector {d,c,b,a} after inputs settle
  task automatic chk_rdy(input string tag, input logic [3:0] exp);
    #1;
    check(tag, 32'({d_ready, c_ready, b_ready, a_ready}), 32'(exp));
  endtask

  task automatic chk_out(input string tag, input logic [WIDTH-1:0] ey,
                         input logic [1:0] esel, input logic ev);
    check({tag, ".y"},   32'(y),          32'(ey));
    check({tag, ".sel"}, 32'({s1, s2}),   32'(esel));
    check({tag, ".vld"}, 32'(y_valid),    32'(ev));
  endtask

  initial begin
    rst = 1'b1; y_ready = 1'b0;
    a = '0; b = '0; c = '0; d = '0;
    set_v(4'b0000);
    tick();
    tick();
    chk_out("reset", 4'h0, 2'b00, 1'b0);

    // Reset then single channel c
    rst = 1'b0; y_ready = 1'b1; c = 4'h1; set_v(4'b0100);
    chk_rdy("single.rdy", 4'b0100);
    tick();
    chk_out("single", 4'h1, 2'b10, 1'b1);
    // ptr now 3: with a, c, d valid, d wins
    set_v(4'b1101);
    chk_rdy("single.ptr3", 4'b1000);

    // Idle drain: valid drops after one cycle, data and tag hold
    set_v(4'b0000);
    chk_rdy("drain.rdy", 4'b0000);
    tick();
    chk_out("drain", 4'h1, 2'b10, 1'b0);

    // Reset to return ptr to 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_out("reset2", 4'h0, 2'b00, 1'b0);

    // All valid, continuous drain: strict rotation, no bubbles
    a = 4'h1; b = 4'h0; c = 4'h1; d = 4'h0;
    set_v(4'b1111);
    for (int k = 0; k < 8; k++) begin
      chk_rdy($sformatf("rot%0d.rdy", k), 4'(1 << (k % 4)));
      tick();
      chk_out($sformatf("rot%0d", k), (k % 2 == 0) ? 4'h1 : 4'h0, 2'(k % 4), 1'b1);
    end

    // Backpressure: load b, then stall with a and d valid
    b = 4'h5; set_v(4'b0010);
    chk_rdy("bp.load.rdy", 4'b0010);
    tick();
    chk_out("bp.load", 4'h5, 2'b01, 1'b1);
    y_ready = 1'b0; a = 4'h9; d = 4'hC; set_v(4'b1001);
    for (int k = 0; k < 3; k++) begin
      chk_rdy($sformatf("bp.stall%0d.rdy", k), 4'b0000);
      tick();
      chk_out($sformatf("bp.stall%0d", k), 4'h5, 2'b01, 1'b1);
    end
    y_ready = 1'b1;
    chk_rdy("bp.rel_d.rdy", 4'b1000);
    tick();
    chk_out("bp.rel_d", 4'hC, 2'b11, 1'b1);
    chk_rdy("bp.rel_a.rdy", 4'b0001);
    tick();
    chk_out("bp.rel_a", 4'h9, 2'b00, 1'b1);

    // Wrap-around: d transfer moves ptr 3 -> 0
    set_v(4'b1000);
    chk_rdy("wrap.d.rdy", 4'b1000);
    tick();
    chk_out("wrap.d", 4'hC, 2'b11, 1'b1);
    set_v(4'b1111);
    chk_rdy("wrap.ptr0", 4'b0001);
    set_v(4'b0001);
    chk_rdy("wrap.a.rdy", 4'b0001);
    tick();
    chk_out("wrap.a", 4'h9, 2'b00, 1'b1);

    // Drain to empty, holds over extra idle cycles
    set_v(4'b0000);
    tick();
    chk_out("idle1", 4'h9, 2'b00, 1'b0);
    tick();
    chk_out("idle2", 4'h9, 2'b00, 1'b0);

    // Empty register accepts even with y_ready low; ptr=1 so c beats nothing else
    y_ready = 1'b0; c = 4'h7; set_v(4'b0100);
    chk_rdy("empty.load.rdy", 4'b0100);
    tick();
    chk_out("empty.load", 4'h7, 2'b10, 1'b1);
    set_v(4'b1111);
    chk_rdy("full.stall.rdy", 4'b0000);

    // Reset mid-stream (held word, ptr=3): word discarded, ptr back to a
    rst = 1'b1;
    tick();
    chk_out("midrst", 4'h0, 2'b00, 1'b0);
    rst = 1'b0; y_ready = 1'b1;
    chk_rdy("midrst.rdy", 4'b0001);
    tick();
    chk_out("midrst.a", 4'h9, 2'b00, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
